hs_reg_pipeline: RTL and testbench



---
 rtl/hs_reg_pipeline.sv | 102 ++++++++++
 tb/tb_hs_reg_pipeline.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_reg_pipeline.sv
// Chain of DEPTH handshake register stages with bubble collapsing,
// synchronous flush and a registered occupancy count.
module hs_reg_pipeline #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 2,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rd,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [DEPTH-1:0]      rdy_s;
  logic                  full_s;

  // A stage can load unless it and every stage downstream is full while the consumer stalls.
  always_comb begin
    rdy_s  = '0;
    full_s = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      full_s = 1'b1;
      for (int j = i; j < DEPTH; j++) begin
        full_s = full_s & vld_q[j];
      end
      rdy_s[i] = dout_rd | ~full_s;
    end
  end

  // Next-state for valid bits and data; invalid bubbles leave data untouched.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (rdy_s[0]) begin
        vld_d[0] = din_vld;
        if (din_vld) begin
          data_d[0] = din;
        end else begin
          data_d[0] = data_q[0];
        end
      end else begin
        vld_d[0]  = vld_q[0];
        data_d[0] = data_q[0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy_s[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end else begin
            data_d[i] = data_q[i];
          end
        end else begin
          vld_d[i]  = vld_q[i];
          data_d[i] = data_q[i];
        end
      end
    end
  end

  // Occupancy is registered alongside the valid bits so it never follows handshake inputs.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + CNT_WIDTH'(vld_d[i]);
    end
  end

  // Stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign din_rd    = rdy_s[0] & ~flush;
  assign dout      = data_q[DEPTH-1];
  assign dout_vld  = vld_q[DEPTH-1] & ~flush;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_hs_reg_pipeline.sv
// Randomised and directed bench for hs_reg_pipeline against a slot-position
// model of in-flight words.
module tb_hs_reg_pipeline;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_vld = 1'b0;
  logic          din_rd;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rd = 1'b0;
  logic [CW-1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: each in-flight word with its stage position, oldest first.
  int            pos_q[$];
  logic [DW-1:0] dat_q[$];
  bit            obs_vld;
  logic [DW-1:0] obs_dout;

  hs_reg_pipeline #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .din_vld(din_vld),
    .din_rd(din_rd), .dout(dout), .dout_vld(dout_vld), .dout_rd(dout_rd),
    .occupancy(occupancy)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A word advances if the slot ahead is empty or its occupant advances;
  // a word in the last slot leaves when the consumer is ready.
  function automatic bit mdl_din_rd(input bit rd, input bit fl);
    bit mv = rd;
    int prev_p = DEPTH;
    if (fl) return 1'b0;
    foreach (pos_q[k]) begin
      mv = (pos_q[k] + 1 != prev_p) || mv;
      prev_p = pos_q[k];
    end
    return (prev_p != 0) || mv;
  endfunction

  task automatic mdl_step(input bit v, input logic [DW-1:0] d, input bit rd, input bit fl);
    bit acc = v && mdl_din_rd(rd, fl);
    bit mv = rd;
    int prev_p = DEPTH;
    if (fl) begin
      pos_q.delete();
      dat_q.delete();
    end else begin
      foreach (pos_q[k]) begin
        mv = (pos_q[k] + 1 != prev_p) || mv;
        prev_p = pos_q[k];
        if (mv) pos_q[k] = pos_q[k] + 1;
      end
      if (pos_q.size() > 0 && pos_q[0] == DEPTH) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (acc) begin
        pos_q.push_back(0);
        dat_q.push_back(d);
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rd, input bit fl, output bit acc);
    bit exp_vld;
    bit exp_rd;
    @(negedge clk);
    din_vld = v; din = d; dout_rd = rd; flush = fl;
    #1;
    exp_rd  = mdl_din_rd(rd, fl);
    exp_vld = !fl && pos_q.size() > 0 && pos_q[0] == DEPTH - 1;
    check_eq("din_rd", 32'(din_rd), 32'(exp_rd));
    check_eq("dout_vld", 32'(dout_vld), 32'(exp_vld));
    if (exp_vld) check_eq("dout", 32'(dout), 32'(dat_q[0]));
    check_eq("occupancy", 32'(occupancy), 32'(pos_q.size()));
    obs_vld  = dout_vld;
    obs_dout = dout;
    acc = v && din_rd;
    @(posedge clk);
    mdl_step(v, d, rd, fl);
  endtask

  initial begin
    bit acc;
    int idx;
    int first;

    // Reset with the clock stopped.
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_dout_vld", 32'(dout_vld), 32'h0);
    check_eq("rst_occ", 32'(occupancy), 32'h0);
    check_eq("rst_din_rd", 32'(din_rd), 32'h1);
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_eq("idle_dout", 32'(dout), 32'h0);

    // Streaming at full rate.
    cycle(1'b1, 8'h11, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b1, 1'b0, acc);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, acc);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Backpressure fill then release.
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'hA0 + idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check_eq("fill_count", 32'(idx), 32'(DEPTH));
    check_eq("fill_occ", 32'(occupancy), 32'(DEPTH));
    check_eq("fill_din_rd", 32'(din_rd), 32'h0);
    cycle(1'b1, 8'(8'hA0 + idx), 1'b1, 1'b0, acc);
    check_eq("fill_first_out", 32'(obs_dout), 32'hA0);
    check_eq("fill_simul_acc", 32'(acc), 32'h1);
    if (acc) idx++;
    while (idx < 6) begin
      cycle(1'b1, 8'(8'hA0 + idx), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Bubble collapse under a stalled consumer.
    cycle(1'b1, 8'h01, 1'b0, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    cycle(1'b1, 8'h02, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check_eq("bub_occ", 32'(occupancy), 32'h2);
    check_eq("bub_din_rd", 32'(din_rd), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("bub_out0", 32'(obs_dout), 32'h01);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check_eq("bub_out1", 32'(obs_dout), 32'h02);
    check_eq("bub_out1_vld", 32'(obs_vld), 32'h1);

    // Flush with three words in flight.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
    cycle(1'b1, 8'hCF, 1'b1, 1'b1, acc);
    check_eq("flush_no_acc", 32'(acc), 32'h0);
    check_eq("flush_no_vld", 32'(obs_vld), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check_eq("flush_drain_vld", 32'(obs_vld), 32'h0);
    end

    // Async reset mid-stream, then latency of a lone word.
    cycle(1'b1, 8'h77, 1'b0, 1'b0, acc);
    cycle(1'b1, 8'h78, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
    @(negedge clk);
    dout_rd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", 32'(dout_vld), 32'h0);
    check_eq("mid_rst_occ", 32'(occupancy), 32'h0);
    check_eq("mid_rst_dout", 32'(dout), 32'h0);
    pos_q.delete();
    dat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
      if (obs_vld && first == 0) begin
        first = k;
        check_eq("lat_dout", 32'(obs_dout), 32'h5A);
      end
    end
    check_eq("lat_edges", 32'(first), 32'(DEPTH));

    // Random traffic with occasional flushes and stall bursts.
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      rd = ((i / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      cycle($urandom_range(0, 3) != 0, 8'($urandom), rd, $urandom_range(0, 29) == 0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
